// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back data cache controller with stall-on-miss FSM
module dcache_ctrl #(
    parameter int NUM_LINES = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cpu_req_i,
    input  logic         cpu_we_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_wdata_i,
    output logic [31:0]  cpu_rdata_o,
    output logic         stall_o,
    output logic         mem_req_o,
    output logic         mem_we_o,
    output logic [31:0]  mem_addr_o,
    output logic [127:0] mem_wdata_o,
    input  logic         mem_ack_i,
    input  logic [127:0] mem_rdata_i
);
    localparam int IW = $clog2(NUM_LINES);
    localparam int TW = 28 - IW;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_REFILL    = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [NUM_LINES-1:0]   valid_q;
    logic [NUM_LINES-1:0]   dirty_q;
    logic [TW-1:0]          tag_q  [NUM_LINES];
    logic [127:0]           data_q [NUM_LINES];

    logic [1:0]    word_sel;
    logic [IW-1:0] idx;
    logic [TW-1:0] addr_tag;
    logic [127:0]  line;
    logic          hit;
    logic          store_hit;
    logic          refill_done;
    logic          unused_addr_bits;

    assign word_sel         = cpu_addr_i[3:2];
    assign idx              = cpu_addr_i[4 +: IW];
    assign addr_tag         = cpu_addr_i[31 -: TW];
    assign unused_addr_bits = ^cpu_addr_i[1:0];
    assign line             = data_q[idx];
    assign hit              = cpu_req_i && valid_q[idx] && (tag_q[idx] == addr_tag);
    assign store_hit        = (state_q == S_IDLE) && hit && cpu_we_i;
    assign refill_done      = (state_q == S_REFILL) && mem_ack_i;

    // Next-state and outputs; the CPU holds its request steady while stalled, so
    // the victim/refill address can be formed directly from the live CPU address.
    always_comb begin
        state_d     = state_q;
        stall_o     = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        cpu_rdata_o = '0;
        case (state_q)
            S_IDLE: begin
                if (cpu_req_i) begin
                    if (hit) begin
                        cpu_rdata_o = line[{word_sel, 5'b0} +: 32];
                    end else begin
                        stall_o = 1'b1;
                        state_d = (valid_q[idx] && dirty_q[idx]) ? S_WRITEBACK : S_REFILL;
                    end
                end
            end
            S_WRITEBACK: begin
                stall_o     = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {tag_q[idx], idx, 4'b0};
                mem_wdata_o = line;
                if (mem_ack_i) state_d = S_REFILL;
            end
            S_REFILL: begin
                stall_o    = 1'b1;
                mem_req_o  = 1'b1;
                mem_addr_o = {addr_tag, idx, 4'b0};
                if (mem_ack_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Reset is asynchronous, so outputs must go quiet in the same cycle it asserts.
        if (!rst_i) begin
            state_d     = S_IDLE;
            stall_o     = 1'b0;
            mem_req_o   = 1'b0;
            mem_we_o    = 1'b0;
            mem_addr_o  = '0;
            mem_wdata_o = '0;
            cpu_rdata_o = '0;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Line status bits: stores mark dirty, a completed refill makes the line clean and valid
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (store_hit) begin
            dirty_q[idx] <= 1'b1;
        end else if (refill_done) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end
    end

    // Tag and data arrays carry no reset; valid bits qualify them
    always_ff @(posedge clk_i) begin
        if (store_hit) begin
            data_q[idx][{word_sel, 5'b0} +: 32] <= cpu_wdata_i;
        end else if (refill_done) begin
            data_q[idx] <= mem_rdata_i;
            tag_q[idx]  <= addr_tag;
        end
    end
endmodule
